adder_pipe_param: RTL and testbench
===================================

// Module: adder_pipe_param
// PURPOSE
//   Parametrised, pipelined add/subtract unit, the next generation of the team's fixed 8/4/1-bit adders.
//   Generalised to any WIDTH, split into SEG-bit carry-chain segments with one register stage per segment.
//   Uses a valid/ready handshake on both sides, so it can sit between a stimulus source and a checker/consumer.
//   Reports carry-out and signed overflow per result.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; must be a multiple of SEG
//   SEG    4  bits added per pipeline stage; STAGES = WIDTH/SEG (latency in cycles)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      a/b/cin/sub are valid this cycle
//   in_ready   out  1      unit accepts an operand set this cycle
//   a          in   WIDTH  operand A (two's complement or unsigned)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
//   out_valid  out  1      sum/cout/ovf hold a result
//   out_ready  in   1      consumer takes the result this cycle
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB (in sub mode 1 = no borrow)
//   ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all stage valid bits, out_valid, sum, cout and ovf go to 0; in-flight data is discarded.
//     in_ready = 0 while rst is high and 1 from the first cycle after reset deassertion.
//   - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//   - Advance: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0.
//     in_ready = adv & !rst. in_ready is combinational from out_ready; no other combinational in-to-out path exists.
//   - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of a and b' (b' = sub ? ~b : b) with the carry from stage k-1.
//     Stage 0 carry-in = sub ? 1 : cin.
//   - Upper operand slices not yet consumed are carried down the pipe with the data.
//     Lower sum slices are carried down as they are produced.
//   - Latency: a result accepted at cycle t is on out_valid at t+STAGES, provided there is no stall.
//   - Throughput: 1 result per cycle with out_ready held high. Bubbles are NOT collapsed: an empty stage still
//     advances only when adv=1.
//   - Stall: while out_valid & !out_ready, sum/cout/ovf stay stable and every stage holds. No loss, no duplication.
//   - Simultaneous: out_ready=1 with out_valid=1 and in_valid=1 means one result leaves and one operand set enters
//     in the same cycle.
//   - in_valid=0 while in_ready=1 inserts a bubble: stage-0 valid=0.
//   - Operands are captured only on transfer; changing a/b while in_ready=0 has no effect.
//   - STAGES=1 (SEG=WIDTH) degenerates to a single registered adder with latency 1.
//   - rst mid-stream flushes every stage immediately; results in flight are never presented.
// STRUCTURE
//   - Package adder_pipe_pkg: localparam function for STAGES; typedef for the per-stage payload
//     (valid, carry, remaining operand slices, partial sum).
//   - Sub-module adder_seg: combinational SEG-bit adder, with carry-in and carry-out and also
//     carry-into-MSB (used by the last stage for ovf).
//     Instantiated STAGES times in a generate loop; the pipeline registers live in adder_pipe_param.
//   - Elaboration check: error if WIDTH % SEG != 0 or SEG < 1.
// TESTING
//   (WIDTH=8, SEG=4, out_ready=1 unless stated)
//   1. Add: a=8'h0F, b=8'h01, cin=0, sub=0 -> 2 cycles later sum=8'h10, cout=0, ovf=0.
//   2. Carry/overflow: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1;
//      a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
//   3. Subtract: a=8'h05, b=8'h07, sub=1, cin=1 -> sum=8'hFE, cout=0, ovf=0 (cin ignored);
//      a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, ovf=1.
//   4. Back-pressure: stream 4 sets back-to-back, drop out_ready for 3 cycles after the first result.
//      -> sum stable during the stall, in_ready=0 during the stall, all 4 results in order with none lost.
//   5. Reset mid-flight: issue 2 sets, assert rst for 1 cycle at the next edge.
//      -> out_valid=0, no stale result ever appears; a new set then completes with latency 2.
//   6. Random: 1000 $random sets with random in_valid/out_ready, also run at WIDTH=16/SEG=4 and WIDTH=8/SEG=8.
//      -> every result matches the reference model {cout,sum} = a + b' + c0, and ovf matches.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the segmented add/subtract pipeline.
package adder_pipe_pkg;

  // Pipeline depth; a degenerate SEG is rejected separately at elaboration.
  function automatic int num_stages(input int width, input int seg);
    if (seg < 1 || (width / seg) < 1) return 1;
    return width / seg;
  endfunction

  // Per-stage control bits: ovf is only meaningful in the last stage.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_flags_t;

endpackage

// File: rtl/adder_pipe_param_seg.sv
// SEG-bit combinational adder slice exposing carry into and out of its MSB.
module adder_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  if (SEG == 1) begin : g_one
    assign c_msb   = ci;
    assign {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
  end else begin : g_multi
    logic [SEG-2:0] low;
    assign {c_msb, low}     = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]} + {{(SEG-1){1'b0}}, ci};
    assign {co, s[SEG-1]}   = {1'b0, a[SEG-1]} + {1'b0, b[SEG-1]} + {1'b0, c_msb};
    assign s[SEG-2:0]       = low;
  end

endmodule

// File: rtl/adder_pipe_param.sv
// Pipelined WIDTH-bit add/subtract unit, one SEG-bit carry segment per register stage,
// with valid/ready on both sides and a single global advance (no bubble collapsing).
module adder_pipe_param
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = num_stages(WIDTH, SEG);

  if (SEG < 1) begin : g_bad_seg
    $error("adder_pipe_param: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_bad_width
    $error("adder_pipe_param: WIDTH must be a multiple of SEG");
  end

  // Operands travel with the data so each stage sees its own slice; sum fills in low-to-high.
  typedef struct packed {
    stage_flags_t     flags;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t st_q [STAGES];
  stage_t st_d [STAGES];
  stage_t in_stage;
  logic   adv;

  assign out_valid = st_q[STAGES-1].flags.valid;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;

  always_comb begin
    in_stage             = '0;
    in_stage.flags.valid = in_valid && in_ready;
    in_stage.flags.carry = sub ? 1'b1 : cin;
    in_stage.a           = a;
    in_stage.b           = sub ? ~b : b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         src;
    stage_t         nxt;
    logic [SEG-1:0] seg_sum;
    logic           seg_co;
    logic           seg_cmsb;

    if (k == 0) begin : g_first
      assign src = in_stage;
    end else begin : g_next
      assign src = st_q[k-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a     (src.a[k*SEG +: SEG]),
      .b     (src.b[k*SEG +: SEG]),
      .ci    (src.flags.carry),
      .s     (seg_sum),
      .co    (seg_co),
      .c_msb (seg_cmsb)
    );

    always_comb begin
      nxt                    = src;
      nxt.sum[k*SEG +: SEG]  = seg_sum;
      nxt.flags.carry        = seg_co;
      nxt.flags.ovf          = seg_cmsb ^ seg_co;
    end

    assign st_d[k] = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
    end
  end

  assign sum  = st_q[STAGES-1].sum;
  assign cout = st_q[STAGES-1].flags.carry;
  assign ovf  = st_q[STAGES-1].flags.ovf;

endmodule

// File: tb/tb_adder_pipe_param.sv
// Directed and random checks of adder_pipe_param at 8/4, 16/4 and 8/8 against a queue scoreboard.
module tb_adder_pipe_param;

  typedef logic [17:0] res_t;  // {ovf, cout, sum[15:0]}

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [15:0] a_bus;
  logic [15:0] b_bus;

  logic        rdy_84, vld_84, co_84, ov_84;
  logic [7:0]  sum_84;
  logic        rdy_164, vld_164, co_164, ov_164;
  logic [15:0] sum_164;
  logic        rdy_88, vld_88, co_88, ov_88;
  logic [7:0]  sum_88;

  res_t q_84[$];
  res_t q_164[$];
  res_t q_88[$];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_pipe_param #(.WIDTH(8), .SEG(4)) u_dut_84 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_84),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin), .sub(sub),
    .out_valid(vld_84), .out_ready(out_ready), .sum(sum_84), .cout(co_84), .ovf(ov_84)
  );

  adder_pipe_param #(.WIDTH(16), .SEG(4)) u_dut_164 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_164),
    .a(a_bus), .b(b_bus), .cin(cin), .sub(sub),
    .out_valid(vld_164), .out_ready(out_ready), .sum(sum_164), .cout(co_164), .ovf(ov_164)
  );

  adder_pipe_param #(.WIDTH(8), .SEG(8)) u_dut_88 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_88),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin), .sub(sub),
    .out_valid(vld_88), .out_ready(out_ready), .sum(sum_88), .cout(co_88), .ovf(ov_88)
  );

  // Reference: full-width add of a, b' and c0; signed overflow from operand/result sign bits.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    logic [16:0] mask, am, bm, full;
    logic        c0, ov;
    mask = (17'd1 << w) - 17'd1;
    am   = {1'b0, a} & mask;
    bm   = (s ? {1'b0, ~b} : {1'b0, b}) & mask;
    c0   = s ? 1'b1 : c;
    full = am + bm + {16'd0, c0};
    ov   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    return {ov, full[w], full[15:0] & mask[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a_v, input logic [15:0] b_v,
                       input logic c_v, input logic s_v, input logic iv);
    a_bus    = a_v;
    b_bus    = b_v;
    cin      = c_v;
    sub      = s_v;
    in_valid = iv;
  endtask

  // Scores transfers of the coming edge, then advances to the next falling edge.
  task automatic cycle();
    #1;
    if (rst) begin
      q_84.delete();
      q_164.delete();
      q_88.delete();
    end else begin
      if (vld_84 && out_ready) begin
        if (q_84.size() == 0) check("sb84_underflow", 32'd1, 32'd0);
        else check("sb84_result", {ov_84, co_84, 8'h00, sum_84}, q_84.pop_front());
      end
      if (vld_164 && out_ready) begin
        if (q_164.size() == 0) check("sb164_underflow", 32'd1, 32'd0);
        else check("sb164_result", {ov_164, co_164, sum_164}, q_164.pop_front());
      end
      if (vld_88 && out_ready) begin
        if (q_88.size() == 0) check("sb88_underflow", 32'd1, 32'd0);
        else check("sb88_result", {ov_88, co_88, 8'h00, sum_88}, q_88.pop_front());
      end
      if (in_valid && rdy_84)  q_84.push_back(model(8, a_bus, b_bus, cin, sub));
      if (in_valid && rdy_164) q_164.push_back(model(16, a_bus, b_bus, cin, sub));
      if (in_valid && rdy_88)  q_88.push_back(model(8, a_bus, b_bus, cin, sub));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] bp_a [4];
  logic [7:0] bp_b [4];
  logic [7:0] bp_e [4];
  res_t       tmp;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state
    check("rst_out_valid", {31'd0, vld_84}, 32'd0);
    check("rst_outputs", {ov_84, co_84, sum_84}, 32'd0);
    #1;
    check("rst_in_ready_low", {31'd0, rdy_84}, 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, rdy_84}, 32'd1);

    // 1. Plain add with latency 2
    drive(16'h000F, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("t1_not_early", {31'd0, vld_84}, 32'd0);
    cycle();
    check("t1_valid", {31'd0, vld_84}, 32'd1);
    check("t1_add", {ov_84, co_84, sum_84}, {22'd0, 1'b0, 1'b0, 8'h10});
    cycle();

    // 2. Carry and overflow, back to back
    drive(16'h007F, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("t2_ovf", {ov_84, co_84, sum_84}, {22'd0, 1'b1, 1'b0, 8'h80});
    cycle();
    check("t2_carry", {ov_84, co_84, sum_84}, {22'd0, 1'b0, 1'b1, 8'h01});
    cycle();

    // 3. Subtract, cin ignored
    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(16'h0080, 16'h0001, 1'b0, 1'b1, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("t3_sub_neg", {ov_84, co_84, sum_84}, {22'd0, 1'b0, 1'b0, 8'hFE});
    cycle();
    check("t3_sub_ovf", {ov_84, co_84, sum_84}, {22'd0, 1'b1, 1'b1, 8'h7F});
    cycle();

    // 4. Back-pressure: 3-cycle stall after the first result
    bp_a = '{8'h12, 8'hF0, 8'hAA, 8'h01};
    bp_b = '{8'h34, 8'h0F, 8'h55, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      tmp     = model(8, {8'h00, bp_a[i]}, {8'h00, bp_b[i]}, 1'b0, 1'b0);
      bp_e[i] = tmp[7:0];
    end
    drive({8'h00, bp_a[0]}, {8'h00, bp_b[0]}, 1'b0, 1'b0, 1'b1);
    cycle();
    drive({8'h00, bp_a[1]}, {8'h00, bp_b[1]}, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t4_first", {23'd0, vld_84, sum_84}, {23'd0, 1'b1, bp_e[0]});
    drive({8'h00, bp_a[2]}, {8'h00, bp_b[2]}, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_in_ready_stall", {31'd0, rdy_84}, 32'd0);
      cycle();
      check("t4_sum_stable", {23'd0, vld_84, sum_84}, {23'd0, 1'b1, bp_e[0]});
    end
    out_ready = 1'b1;
    cycle();
    check("t4_second", {23'd0, vld_84, sum_84}, {23'd0, 1'b1, bp_e[1]});
    drive({8'h00, bp_a[3]}, {8'h00, bp_b[3]}, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t4_third", {23'd0, vld_84, sum_84}, {23'd0, 1'b1, bp_e[2]});
    in_valid = 1'b0;
    cycle();
    check("t4_fourth", {23'd0, vld_84, sum_84}, {23'd0, 1'b1, bp_e[3]});
    cycle();
    check("t4_drained", {31'd0, vld_84}, 32'd0);
    repeat (4) cycle();

    // 5. Reset with two sets in flight
    drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1);
    cycle();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t5_in_ready_in_rst", {31'd0, rdy_84}, 32'd0);
    cycle();
    rst = 1'b0;
    check("t5_flushed", {31'd0, vld_84}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_no_stale", {29'd0, vld_84, vld_164, vld_88}, 32'd0);
    end
    drive(16'h0021, 16'h0043, 1'b0, 1'b0, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("t5_not_early", {31'd0, vld_84}, 32'd0);
    cycle();
    check("t5_after_rst", {23'd0, vld_84, sum_84}, {23'd0, 1'b1, 8'h64});
    cycle();

    // 6. Random traffic, random back-pressure
    for (int i = 0; i < 1000; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) cycle();
    check("sb84_empty", q_84.size(), 32'd0);
    check("sb164_empty", q_164.size(), 32'd0);
    check("sb88_empty", q_88.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
